// File: rtl/tpu_pkg.sv
// Shared types, default widths and arithmetic helpers for the systolic matrix-multiply core.
package tpu_pkg;

  localparam int DEF_ROWS       = 4;
  localparam int DEF_COLS       = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ACC_WIDTH  = 24;
  localparam int DEF_KLEN_WIDTH = 8;

  // Saturating adds are evaluated at this width; accumulators must be narrower.
  localparam int SAT_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int                      w
  );
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/systolic_array_core_if.sv
// Operand-stream, control and result bundle of the systolic core; master drives operands.
interface systolic_array_core_if
  import tpu_pkg::*;
#(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int KLEN_WIDTH = DEF_KLEN_WIDTH
) ();

  logic                           start;
  logic [KLEN_WIDTH-1:0]          k_len;
  logic                           in_valid;
  logic                           in_ready;
  logic [ROWS*DATA_WIDTH-1:0]     a_in;
  logic [COLS*DATA_WIDTH-1:0]     b_in;
  logic                           busy;
  logic                           done;
  logic [ROWS*COLS*ACC_WIDTH-1:0] c_out;

  modport master (
    output start, k_len, in_valid, a_in, b_in,
    input  in_ready, busy, done, c_out
  );

  modport slave (
    input  start, k_len, in_valid, a_in, b_in,
    output in_ready, busy, done, c_out
  );

endinterface

// File: rtl/systolic_array_core_pe.sv
// Multiply-accumulate processing element: forwards a right and b down, accumulates a*b.
// Build option SYSTOLIC_SATURATE_EN selects a clamping accumulator instead of wrap-around.
module pe_acc
  import tpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  input  logic signed [DATA_WIDTH-1:0] b_in,
  output logic signed [DATA_WIDTH-1:0] a_out,
  output logic signed [DATA_WIDTH-1:0] b_out,
  output logic signed [ACC_WIDTH-1:0]  c_out
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext;
  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [ACC_WIDTH-1:0]    acc_nxt;

  assign prod     = (2*DATA_WIDTH)'(a_in) * (2*DATA_WIDTH)'(b_in);
  assign prod_ext = ACC_WIDTH'(prod);

  always_comb begin
`ifdef SYSTOLIC_SATURATE_EN
    acc_nxt = ACC_WIDTH'(sat_add(SAT_W'(acc), SAT_W'(prod_ext), ACC_WIDTH));
`else
    acc_nxt = acc + prod_ext;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc_nxt;
    end
  end

  assign c_out = acc;

endmodule

// File: rtl/systolic_array_core.sv
// Output-stationary systolic matrix multiplier: sequencing FSM, input skew and PE grid.
// Build option SYSTOLIC_SATURATE_EN (in pe_acc) makes accumulators saturate.
//
//   state    | meaning
//   ST_IDLE  | waiting for start; results of the last run held
//   ST_FEED  | accepting k_len operand beats (in_ready=1)
//   ST_DRAIN | zeros flush the skewed wavefront for ROWS+COLS-1 cycles
//   ST_DONE  | one-cycle done pulse; a new start may be taken here
module systolic_array_core
  import tpu_pkg::*;
#(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int KLEN_WIDTH = DEF_KLEN_WIDTH
) (
  input logic                  clk,
  input logic                  rst_n,
  systolic_array_core_if.slave bus
);

  localparam int                 DRAIN_W    = $clog2(ROWS + COLS);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(ROWS + COLS - 2);

  state_t                state, state_nxt;
  logic [KLEN_WIDTH-1:0] k_len_q;
  logic [KLEN_WIDTH-1:0] beat_cnt;
  logic [DRAIN_W-1:0]    drain_cnt;
  logic                  start_acc;
  logic                  xfer;
  logic                  last_beat;
  logic                  in_ready_c;
  logic                  busy_c;
  logic                  done_c;

  assign start_acc = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
  assign xfer      = bus.in_valid && (state == ST_FEED);
  assign last_beat = (beat_cnt == k_len_q - KLEN_WIDTH'(1));

  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_acc) state_nxt = (bus.k_len == '0) ? ST_DONE : ST_FEED;
      end
      ST_FEED: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b1;
        if (xfer && last_beat) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy_c = 1'b1;
        if (drain_cnt == '0) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done_c    = 1'b1;
        state_nxt = ST_IDLE;
        if (start_acc) state_nxt = (bus.k_len == '0) ? ST_DONE : ST_FEED;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      k_len_q   <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        k_len_q  <= bus.k_len;
        beat_cnt <= '0;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + KLEN_WIDTH'(1);
      end
      if ((state == ST_FEED) && (state_nxt == ST_DRAIN)) begin
        drain_cnt <= DRAIN_LAST;
      end else if ((state == ST_DRAIN) && (drain_cnt != '0)) begin
        drain_cnt <= drain_cnt - DRAIN_W'(1);
      end
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.busy     = busy_c;
  assign bus.done     = done_c;

  // Non-transfer cycles feed zeros, so bubbles and drain never disturb the sums.
  logic signed [DATA_WIDTH-1:0] a_edge [ROWS];
  logic signed [DATA_WIDTH-1:0] b_edge [COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    logic signed [DATA_WIDTH-1:0] a_new;
    assign a_new = xfer ? $signed(bus.a_in[DATA_WIDTH*r +: DATA_WIDTH]) : '0;
    if (r == 0) begin : g_direct
      assign a_edge[r] = a_new;
    end else begin : g_dly
      logic signed [DATA_WIDTH-1:0] sr [r];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < r; i++) sr[i] <= '0;
        end else if (start_acc) begin
          for (int i = 0; i < r; i++) sr[i] <= '0;
        end else begin
          sr[0] <= a_new;
          for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
        end
      end
      assign a_edge[r] = sr[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_b_skew
    logic signed [DATA_WIDTH-1:0] b_new;
    assign b_new = xfer ? $signed(bus.b_in[DATA_WIDTH*c +: DATA_WIDTH]) : '0;
    if (c == 0) begin : g_direct
      assign b_edge[c] = b_new;
    end else begin : g_dly
      logic signed [DATA_WIDTH-1:0] sr [c];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < c; i++) sr[i] <= '0;
        end else if (start_acc) begin
          for (int i = 0; i < c; i++) sr[i] <= '0;
        end else begin
          sr[0] <= b_new;
          for (int i = 1; i < c; i++) sr[i] <= sr[i-1];
        end
      end
      assign b_edge[c] = sr[c-1];
    end
  end

  logic signed [DATA_WIDTH-1:0] a_fwd [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0] b_fwd [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0]  acc   [ROWS][COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic signed [DATA_WIDTH-1:0] a_pe;
      logic signed [DATA_WIDTH-1:0] b_pe;
      if (c == 0) begin : g_a_edge
        assign a_pe = a_edge[r];
      end else begin : g_a_left
        assign a_pe = a_fwd[r][c-1];
      end
      if (r == 0) begin : g_b_edge
        assign b_pe = b_edge[c];
      end else begin : g_b_up
        assign b_pe = b_fwd[r-1][c];
      end
      pe_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_acc),
        .a_in  (a_pe),
        .b_in  (b_pe),
        .a_out (a_fwd[r][c]),
        .b_out (b_fwd[r][c]),
        .c_out (acc[r][c])
      );
    end
  end

  logic [ROWS*COLS*ACC_WIDTH-1:0] c_flat;

  always_comb begin
    c_flat = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        c_flat[ACC_WIDTH*(r*COLS+c) +: ACC_WIDTH] = acc[r][c];
      end
    end
  end

  assign bus.c_out = c_flat;

endmodule

// File: doc/systolic_array_core.md
SYSTOLIC_ARRAY_CORE -- requirements
Module: systolic_array_core

Interface
REQ-001 Parameter ROWS, default 4, number of PE rows (output-matrix rows, M).
REQ-002 Parameter COLS, default 4, number of PE columns (output-matrix columns, N).
REQ-003 Parameter DATA_WIDTH, default 8, signed operand width.
REQ-004 Parameter ACC_WIDTH, default 24, signed accumulator width; must be at least 2*DATA_WIDTH.
REQ-005 Parameter KLEN_WIDTH, default 8, width of the reduction-length input.
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 start  input  1  one-cycle request to begin a matrix multiply.
REQ-009 k_len  input  KLEN_WIDTH  reduction depth K; sampled when start is accepted.
REQ-010 in_valid  input  1  a_in/b_in beat valid.
REQ-011 in_ready  output  1  block accepts a beat this cycle.
REQ-012 a_in  input  ROWS*DATA_WIDTH  one A column; element r at bits [DATA_WIDTH*(r+1)-1 : DATA_WIDTH*r].
REQ-013 b_in  input  COLS*DATA_WIDTH  one B row; element c packed the same way.
REQ-014 busy  output  1  high from start acceptance until done.
REQ-015 done  output  1  one-cycle pulse; c_out valid from this cycle until next accepted start.
REQ-016 c_out  output  ROWS*COLS*ACC_WIDTH  results, row-major; index r*COLS+c.

Function
REQ-017 FSM states IDLE, FEED, DRAIN, DONE; IDLE -> FEED on start when k_len>0; IDLE -> DONE on start when k_len==0.
REQ-018 Start is accepted only in IDLE or DONE; start in FEED/DRAIN is ignored.
REQ-019 On start acceptance, all accumulators clear to 0 in the same edge, and the beat counter clears.
REQ-020 in_ready = 1 only in FEED; a beat transfers when in_valid && in_ready.
REQ-021 FEED -> DRAIN on the edge that transfers beat number k_len.
REQ-022 Each cycle in FEED without a transfer injects zeros into the skew stage, a bubble that changes no result.
REQ-023 Internal skew: a_in row r is delayed r cycles and b_in column c is delayed c cycles before entering the array edge.
REQ-024 Each PE forwards a right and b down with one register each, and adds the a*b product to its accumulator each cycle.
REQ-025 DRAIN lasts exactly ROWS+COLS-1 cycles, counted by a drain counter; inputs to the array are zero; DRAIN -> DONE afterwards.
REQ-026 In DONE, done=1 for one cycle, then the FSM goes to IDLE unless start is accepted in that same cycle.
REQ-027 busy = 1 in FEED and DRAIN, else 0.
REQ-028 Arithmetic: the product is signed DATA_WIDTH x DATA_WIDTH -> 2*DATA_WIDTH and is sign-extended to ACC_WIDTH.
REQ-029 Accumulation wraps modulo 2^ACC_WIDTH unless the feature in REQ-034 is compiled in.
REQ-030 c_out holds its value from done until the next accepted start, which zeroes it.
REQ-031 c_out[r][c] = sum over k of A[r][k]*B[k][c], where beat k carries A column k and B row k.

Reset
REQ-032 While rst_n=0, the FSM is in IDLE and accumulators, skew registers, pipeline registers and counters are 0.
REQ-033 Outputs under reset: in_ready=0, busy=0, done=0, c_out=0. Reset mid-FEED/DRAIN aborts the operation, with no done pulse.

Configuration
REQ-034 Macro SYSTOLIC_SATURATE_EN: when defined, each accumulator add clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; when undefined, two's-complement wrap.

Structure
REQ-035 The shared package tpu_pkg holds the FSM state enum, the default width constants and the saturating-add function.
REQ-036 The PE is sub-module pe_acc, one instance per grid point, with ports clk, rst_n, clr, a_in, b_in, a_out, b_out, c_out. The skew registers and FSM sit in systolic_array_core.

Verification (defaults unless stated)
REQ-037 A = identity 4x4, B rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, K=4, in_valid held high -> c_out = B.
REQ-038 Timing check, same stimulus: done rises exactly 4+7 cycles after the cycle in which the first beat transfers, and busy falls in the done cycle.
REQ-039 All operands 1, K=4, in_valid gaps of 3 cycles after beats 1 and 3 -> every c_out = 4, and done is delayed by 6 cycles relative to the no-gap case.
REQ-040 ACC_WIDTH=16, all operands 127, K=3 -> each c_out = -17149 without SYSTOLIC_SATURATE_EN, and 32767 with it.
REQ-041 start with k_len=0 -> DONE next cycle and c_out all 0. start pulsed during DRAIN -> ignored and the results are unchanged.
REQ-042 rst_n asserted after beat 2 of K=4 -> the same cycle shows busy=0, in_ready=0, c_out=0; a following run with all operands 2, K=4 yields 16 everywhere.
